// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction-memory arbiter.
//   imem_state_t : arbiter sequencing state (BOOT holds the CPU, RUN shares the port)
//   IMEM_DEPTH   : default memory depth in 32-bit words
//   IMEM_AW      : default word-index width
//   word_idx()   : byte address -> word index (low two bits dropped)
package imem_pkg;

    typedef enum logic {ST_BOOT, ST_RUN} imem_state_t;

    localparam int IMEM_DEPTH = 1024;
    localparam int IMEM_AW    = 10;

    function automatic logic [29:0] word_idx(input logic [31:0] addr);
        return addr[31:2];
    endfunction

endpackage

// File: rtl/imem_burst_limiter.sv
// imem_burst_limiter: counts consecutive loader grants made while the CPU is
// waiting to fetch in RUN, and forces one fetch grant once MAX_LD_BURST is reached.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   run          : arbiter is in RUN (counter held clear otherwise)
//   fetch_req    : CPU fetch request
//   ld_grant     : loader write granted this cycle
//   fetch_grant  : fetch granted this cycle
//   force_fetch  : block the loader this cycle so fetch gets the port
module imem_burst_limiter #(
    parameter int MAX_LD_BURST = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic fetch_req,
    input  logic ld_grant,
    input  logic fetch_grant,
    output logic force_fetch
);

    localparam int BW = $clog2(MAX_LD_BURST + 1);
    localparam logic [BW-1:0] LIMIT = BW'(MAX_LD_BURST);

    logic [BW-1:0] cnt_q, cnt_d;

    // Depends only on the registered count, so no loop through the grant logic.
    assign force_fetch = run & fetch_req & (cnt_q == LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (!run || !fetch_req || fetch_grant)
            cnt_d = '0;
        else if (ld_grant && cnt_q != LIMIT)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares a single-port, word-addressed instruction memory between
// CPU fetch and a program loader. BOOT holds the CPU while the loader writes the
// image; RUN releases fetch, with loader writes still taking priority.
// Grants and mem_* are combinational (zero-latency reads).
// Optional build macro: IMEM_FAIR_EN -- caps consecutive loader grants while
// fetch waits at MAX_LD_BURST, then grants one fetch.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   fetch_req/addr, fetch_ack/data   : CPU fetch side
//   ld_valid/addr/data, ld_ready     : loader write side (valid&ready = transfer)
//   ld_start, ld_done                : enter BOOT / release CPU pulses
//   cpu_hold                         : CPU freeze
//   ld_count                         : in-range words accepted since BOOT entry (saturating)
//   oor_err                          : sticky out-of-range loader address
//   mem_addr/we/wdata, mem_rdata     : memory port
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int DEPTH        = IMEM_DEPTH,
    parameter int AW           = IMEM_AW,
    parameter int CNT_W        = 16,
    parameter int MAX_LD_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_req,
    input  logic [31:0]      fetch_addr,
    output logic             fetch_ack,
    output logic [31:0]      fetch_data,
    input  logic             ld_valid,
    input  logic [31:0]      ld_addr,
    input  logic [31:0]      ld_data,
    output logic             ld_ready,
    input  logic             ld_start,
    input  logic             ld_done,
    output logic             cpu_hold,
    output logic [CNT_W-1:0] ld_count,
    output logic             oor_err,
    output logic [31:0]      mem_addr,
    output logic             mem_we,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    if (MAX_LD_BURST < 1) begin : g_bad_burst
        $error("imem_arbiter: MAX_LD_BURST must be at least 1");
    end

    imem_state_t      state_q, state_d;
    logic [CNT_W-1:0] ld_count_q, ld_count_d;
    logic             oor_err_q, oor_err_d;

    logic        run, ld_grant, in_range, force_fetch;
    logic [29:0] widx;

    assign run  = (state_q == ST_RUN);
    assign widx = word_idx(ld_addr);
    // Upper index bits must be zero and the low AW bits below DEPTH.
    assign in_range = ~|widx[29:AW] & ({1'b0, widx[AW-1:0]} < (AW+1)'(DEPTH));

    assign ld_ready   = run ? ~force_fetch : 1'b1;
    assign ld_grant   = ld_valid & ld_ready;
    assign fetch_ack  = run & fetch_req & ~ld_grant;
    assign fetch_data = fetch_ack ? mem_rdata : 32'h0;
    assign mem_addr   = ld_grant ? ld_addr : fetch_addr;
    assign mem_we     = ld_grant & in_range;
    assign mem_wdata  = ld_data;
    assign cpu_hold   = ~run;
    assign ld_count   = ld_count_q;
    assign oor_err    = oor_err_q;

`ifdef IMEM_FAIR_EN
    imem_burst_limiter #(.MAX_LD_BURST(MAX_LD_BURST)) u_burst (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .fetch_req   (fetch_req),
        .ld_grant    (ld_grant),
        .fetch_grant (fetch_ack),
        .force_fetch (force_fetch)
    );
`else
    assign force_fetch = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        ld_count_d = ld_count_q;
        oor_err_d  = oor_err_q | (ld_grant & ~in_range);

        // Simultaneous start+done is ambiguous and therefore ignored.
        case (state_q)
            ST_BOOT: if (ld_done && !ld_start) state_d = ST_RUN;
            ST_RUN:  if (ld_start && !ld_done) state_d = ST_BOOT;
            default: state_d = ST_BOOT;
        endcase

        // A word accepted alongside ld_start is written, but the count restarts.
        if (run && ld_start && !ld_done)
            ld_count_d = '0;
        else if (mem_we && !(&ld_count_q))
            ld_count_d = ld_count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            ld_count_q <= '0;
            oor_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_count_q <= ld_count_d;
            oor_err_q  <= oor_err_d;
        end
    end

endmodule
